alu_entry_controller: RTL

Sequencing controller for the 4-bit ALU datapath and the four-digit seven-segment renderer. Debounces three push-buttons and steps an operand-entry FSM: ARG0, ARG1, OP, RES. Latches operands and opcode from the switches, drives the ALU inputs, and captures the ALU result. Produces the blinking 16-bit graphics buffer (four 4-bit glyph codes) consumed by the display renderer.

---
 rtl/alu_entry_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_entry_controller.sv
// Operand-entry sequencer for the 4-bit ALU: debounces the three buttons, steps
// ARG0/ARG1/OP/RES, latches operands, captures the result and builds the glyph buffer.
module alu_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnNext,
  input  logic        btnBack,
  input  logic        btnClear,
  input  logic [11:0] sw,
  input  logic [3:0]  aluOut,
  input  logic        aluCout,
  output logic [3:0]  aluX,
  output logic [3:0]  aluY,
  output logic [3:0]  aluSel,
  output logic [15:0] gbuf,
  output logic [1:0]  state,
  output logic        resultValid
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BKW = $clog2(BLINK_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);
  localparam logic [BKW-1:0] BK_MAX = BKW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {ARG0 = 2'd0, ARG1 = 2'd1, OP = 2'd2, RES = 2'd3} state_t;

  state_t           st;
  logic [2:0]       btn_raw, sync1, sync2, level, level_q, press;
  logic [DBW-1:0]   db_cnt [3];
  logic [BKW-1:0]   blink_cnt;
  logic             blink;
  logic [3:0]       res;
  logic             cout;
  logic [3:0]       value;
  logic [15:0]      gbuf_next;

  // bit 2 = Clear, bit 1 = Back, bit 0 = Next
  assign btn_raw = {btnClear, btnBack, btnNext};
  assign press   = level & ~level_q;
  assign state   = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= level;
      for (int unsigned i = 0; i < 3; i++) begin
        if (!sync2[i]) begin
          db_cnt[i] <= '0;
          level[i]  <= 1'b0;
        end else if (db_cnt[i] != DB_MAX) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
          if (db_cnt[i] == DB_MAX - 1'b1) level[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    value     = aluX;
    gbuf_next = 16'h0CBA;
    case (st)
      ARG0: value = aluX;
      ARG1: value = aluY;
      OP:   value = aluSel;
      default: value = res;
    endcase
    if (blink && !(st == RES && !resultValid)) begin
      gbuf_next = {value % 4'd10, value / 4'd10, 4'hF, (st == RES) ? {3'b000, cout} : 4'hF};
    end else begin
      case (st)
        ARG0: gbuf_next = 16'h0CBA;
        ARG1: gbuf_next = 16'h1CBA;
        OP:   gbuf_next = 16'hE1D5;
        default: gbuf_next = 16'hE5DB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ARG0;
      aluX        <= '0;
      aluY        <= '0;
      aluSel      <= '0;
      res         <= '0;
      cout        <= 1'b0;
      resultValid <= 1'b0;
      blink_cnt   <= '0;
      blink       <= 1'b0;
      gbuf        <= 16'hFFFF;
    end else begin
      gbuf <= gbuf_next;

      case (st)
        ARG0: aluX   <= sw[3:0];
        ARG1: aluY   <= sw[7:4];
        OP:   aluSel <= sw[11:8];
        default: begin
          if (!resultValid) begin
            res         <= aluOut;
            cout        <= aluCout;
            resultValid <= 1'b1;
          end
        end
      endcase

      if (blink_cnt == BK_MAX) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // Later assignments override the latch/capture/blink updates above;
      // a Back press in ARG0 is swallowed so a concurrent Next is discarded too.
      if (press[2]) begin
        st          <= ARG0;
        aluX        <= '0;
        aluY        <= '0;
        aluSel      <= '0;
        resultValid <= 1'b0;
        blink_cnt   <= '0;
        blink       <= 1'b0;
      end else if (press[1]) begin
        if (st != ARG0) begin
          st          <= state_t'(st - 2'd1);
          resultValid <= 1'b0;
          blink_cnt   <= '0;
          blink       <= 1'b0;
        end
      end else if (press[0]) begin
        st          <= state_t'(st + 2'd1);
        resultValid <= 1'b0;
        blink_cnt   <= '0;
        blink       <= 1'b0;
      end
    end
  end

endmodule
